// File: rtl/nbyone_scan_mux.sv
// Registered N:1 multiplexer with manual select and round-robin scan over enabled channels.
// Y and CH are always updated on the same edge, so Y always carries data of channel CH.
module nbyone_scan_mux #(
    parameter int WIDTH = 1,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [N_CH*WIDTH-1:0]   i_i,
    input  logic [SEL_W-1:0]        s_i,
    input  logic                    mode_i,
    input  logic [N_CH-1:0]         en_mask_i,
    output logic [WIDTH-1:0]        y_o,
    output logic [SEL_W-1:0]        ch_o,
    output logic                    vld_o,
    output logic                    adv_o
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_MANUAL     = 2'd0,
        ST_SCAN_DWELL = 2'd1,
        ST_SCAN_NONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              vld_q, vld_d;
    logic              adv_q, adv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [WIDTH-1:0] sel_data(input logic [N_CH*WIDTH-1:0] bus,
                                                  input logic [SEL_W-1:0] idx);
        logic [N_CH*WIDTH-1:0] sh;
        sh = bus >> (int'(idx) * WIDTH);
        return sh[WIDTH-1:0];
    endfunction

    function automatic logic chan_en(input logic [N_CH-1:0] mask,
                                     input logic [SEL_W-1:0] idx);
        logic [N_CH-1:0] sh;
        sh = mask >> idx;
        return sh[0];
    endfunction

    // First enabled channel at or above start, wrapping; start itself if mask is empty.
    function automatic logic [SEL_W-1:0] first_en(input logic [N_CH-1:0] mask,
                                                  input int start);
        logic [SEL_W-1:0] res;
        logic             found;
        logic [N_CH-1:0]  sh;
        int               c;
        res   = SEL_W'(start);
        found = 1'b0;
        for (int off = 0; off < N_CH; off++) begin
            c = start + off;
            if (c >= N_CH) begin
                c = c - N_CH;
            end else begin
                c = c;
            end
            sh = mask >> c;
            if (!found && sh[0]) begin
                res   = SEL_W'(c);
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    // Next-state and next-output computation for manual and scan modes.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        y_d     = '0;
        vld_d   = 1'b0;
        adv_d   = 1'b0;
        if (!mode_i) begin
            state_d = ST_MANUAL;
            ch_d    = s_i;
            cnt_d   = '0;
            if ((int'(s_i) < N_CH) && chan_en(en_mask_i, s_i)) begin
                y_d   = sel_data(i_i, s_i);
                vld_d = 1'b1;
            end else begin
                y_d   = '0;
                vld_d = 1'b0;
            end
        end else if (en_mask_i == {N_CH{1'b0}}) begin
            state_d = ST_SCAN_NONE;
            cnt_d   = '0;
        end else begin
            state_d = ST_SCAN_DWELL;
            if (state_q != ST_SCAN_DWELL) begin
                // Entering scan: out-of-range CH restarts the search from channel 0.
                ch_d  = first_en(en_mask_i, (int'(ch_q) < N_CH) ? int'(ch_q) : 0);
                cnt_d = '0;
            end else if (!chan_en(en_mask_i, ch_q) || (cnt_q == CNT_LAST)) begin
                ch_d  = first_en(en_mask_i, (int'(ch_q) + 1 >= N_CH) ? 0 : int'(ch_q) + 1);
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            adv_d = (ch_d != ch_q);
            y_d   = sel_data(i_i, ch_d);
            vld_d = 1'b1;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_MANUAL;
            ch_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
            adv_q   <= adv_d;
        end
    end

    assign y_o   = y_q;
    assign ch_o  = ch_q;
    assign vld_o = vld_q;
    assign adv_o = adv_q;

endmodule
